// File: rtl/mul_unsigned_pkg.sv
// Shared types and constants for the mul_unsigned family.
// Holds the controller state encoding, the legal operand-width range and the
// counter-width helper used by the sequential multiplier.
package mul_unsigned_pkg;

  // Controller states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mul_state_t;

  // Legal range of the operand width parameter.
  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 32;

  // The step counter must be able to represent values 0..WIDTH.
  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mul_unsigned_pp_row.sv
// Partial-product row generator: gates the multiplicand with one multiplier bit.
// Purely combinational; the controller instantiates it once and feeds it the
// current (shifted) multiplicand and the current multiplier LSB.
module mul_unsigned_pp_row #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic             sel,
  output logic [WIDTH-1:0] row
);

  // One AND gate per bit of the row.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_row_bit
      assign row[gi] = a[gi] & sel;
    end
  endgenerate

endmodule

// File: rtl/mul_unsigned_seq.sv
// Sequential shift-add unsigned multiplier with valid/ready on both sides.
// One partial-product row is accumulated per clock; the product appears on z
// with out_valid a fixed WIDTH cycles after the operand pair is accepted.
// Optional feature macro: MUL_SEQ_SKIP_ZERO_EN -- when defined, the BUSY phase
// ends early once the remaining multiplier bits are all zero, so latency becomes
// max(1, msb_index(b)+1) cycles.
module mul_unsigned_seq
  import mul_unsigned_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic               busy
);

  localparam int PW    = 2 * WIDTH;
  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  mul_state_t       state_reg, state_next;
  logic [PW-1:0]    mcand_reg, mcand_next;
  logic [PW-1:0]    acc_reg, acc_next;
  logic [PW-1:0]    z_reg, z_next;
  logic [WIDTH-1:0] mplier_reg, mplier_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [PW-1:0]    row;
  logic [PW-1:0]    acc_sum;
  logic             accept;
  logic             zero_exit;
  logic             finish;

  // Row for this step: shifted multiplicand gated by the current multiplier LSB.
  mul_unsigned_pp_row #(
    .WIDTH(PW)
  ) u_pp_row (
    .a   (mcand_reg),
    .sel (mplier_reg[0]),
    .row (row)
  );

  assign acc_sum = acc_reg + row;

`ifdef MUL_SEQ_SKIP_ZERO_EN
  // Post-shift multiplier is zero when every bit above the LSB is clear, so
  // no further rows can contribute and the product is already final.
  assign zero_exit = (mplier_reg[WIDTH-1:1] == '0);
`else
  assign zero_exit = 1'b0;
`endif

  assign accept = in_valid && in_ready;
  assign finish = (state_reg == ST_BUSY) && ((cnt_reg == CNT_LAST) || zero_exit);

  // Next state and handshake outputs, all decoded from the registered state.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      ST_IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_next = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (finish) begin
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
        busy       = 1'b0;
      end
    endcase
  end

  // Datapath next values: load on accept, shift-add while busy, capture z on finish.
  always_comb begin
    mcand_next  = mcand_reg;
    mplier_next = mplier_reg;
    acc_next    = acc_reg;
    cnt_next    = cnt_reg;
    z_next      = z_reg;
    if (accept) begin
      mcand_next  = {{WIDTH{1'b0}}, a};
      mplier_next = b;
      acc_next    = '0;
      cnt_next    = '0;
    end else if (state_reg == ST_BUSY) begin
      acc_next    = acc_sum;
      mcand_next  = mcand_reg << 1;
      mplier_next = mplier_reg >> 1;
      cnt_next    = cnt_reg + CNT_ONE;
      if (finish) begin
        z_next = acc_sum;
      end
    end
  end

  // State and datapath registers; reset drops any in-flight operation.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      cnt_reg    <= '0;
      z_reg      <= '0;
    end else begin
      state_reg  <= state_next;
      mcand_reg  <= mcand_next;
      mplier_reg <= mplier_next;
      acc_reg    <= acc_next;
      cnt_reg    <= cnt_next;
      z_reg      <= z_next;
    end
  end

  assign z = z_reg;

endmodule
